// File: rtl/serial_pkg.sv
// Shared state encoding, parity-mode constants and parity helper for the serial receiver.
package serial_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // data_xor is the XOR of all data bits; returns 1 when the parity bit disagrees with the mode.
    function automatic logic parity_mismatch(input logic data_xor, input logic par_bit, input int mode);
        logic sum;
        sum = data_xor ^ par_bit;
        return (mode == PARITY_ODD) ? ~sum : sum;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Down-counting bit timer: loads on a strobe, holds at zero and flags expiry while at zero.
module bit_timer #(
    parameter int WIDTH = 4
) (
    input  logic             m_clock,
    input  logic             p_reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/serial_rx.sv
// Asynchronous serial receiver with mid-bit sampling, optional parity, framing check and a
// one-word valid/ready output buffer that drops (and flags) frames completing while it is full.
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 650,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 0
) (
    input  logic                 m_clock,
    input  logic                 p_reset,
    input  logic                 RDX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = 4;
    localparam logic [TW-1:0] HALF_BIT  = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] FULL_BIT  = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frm_perr_q, frm_perr_d;
    logic                 frm_ferr_q, frm_ferr_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic          rxs;
    logic          stop_err;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_expire;

    assign sync_d = {sync_q[0], RDX};
    assign rxs    = sync_q[1];

    bit_timer #(
        .WIDTH(TW)
    ) u_bit_timer (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .expire  (tmr_expire)
    );

    // Frame FSM: every sample is taken when the timer expires, which lands mid-bit after the half-bit start wait.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        frm_perr_d = frm_perr_q;
        frm_ferr_d = frm_ferr_q;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = FULL_BIT;
        stop_err   = frm_ferr_q | ~rxs;
        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d    = S_START;
                    tmr_load   = 1'b1;
                    tmr_val    = HALF_BIT;
                    bit_cnt_d  = '0;
                    frm_perr_d = 1'b0;
                    frm_ferr_d = 1'b0;
                end
            end
            S_START: begin
                if (tmr_expire) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_DATA;
                        tmr_load = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (MSB_FIRST != 0) begin
                        shift_d = {shift_q[DATA_BITS-2:0], rxs};
                    end else begin
                        shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    end
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (tmr_expire) begin
                    tmr_load   = 1'b1;
                    frm_perr_d = parity_mismatch(^shift_q, rxs, PARITY);
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (tmr_expire) begin
                    frm_ferr_d = stop_err;
                    if (bit_cnt_q == LAST_STOP) begin
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = stop_err ? S_WAIT_HIGH : S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tmr_load  = 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output buffer: a completed frame loads only if the buffer is empty or being emptied this cycle.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        if (done_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                parity_err_d = frm_perr_q;
                frame_err_d  = frm_ferr_q;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_q      <= S_IDLE;
            sync_q       <= 2'b11;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            frm_perr_q   <= 1'b0;
            frm_ferr_q   <= 1'b0;
            done_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            frm_perr_q   <= frm_perr_d;
            frm_ferr_q   <= frm_ferr_d;
            done_q       <= done_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx: three configurations (8N1 LSB, even parity, odd parity/2 stop/MSB first).
module tb_serial_rx;

    localparam int NI = 3;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       drop;
    } exp_t;

    logic       m_clock = 1'b0;
    logic       p_reset = 1'b1;
    logic       rdx        [NI];
    logic       rx_ready   [NI];
    logic [7:0] rx_data_w  [NI];
    logic       rx_valid_w [NI];
    logic       perr_w     [NI];
    logic       ferr_w     [NI];
    logic       overrun_w  [NI];
    logic       busy_w     [NI];

    int   ready_mode     [NI];
    int   valid_cycles   [NI];
    int   busy_cycles    [NI];
    int   overrun_cycles [NI];
    logic       prev_valid [NI];
    logic       prev_ready [NI];
    logic       prev_ovr   [NI];
    logic [7:0] prev_data  [NI];
    logic       prev_perr  [NI];
    logic       prev_ferr  [NI];

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 m_clock = ~m_clock;

    serial_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(0)) dut0 (
        .m_clock(m_clock), .p_reset(p_reset), .RDX(rdx[0]), .rx_data(rx_data_w[0]),
        .rx_valid(rx_valid_w[0]), .rx_ready(rx_ready[0]), .parity_err(perr_w[0]),
        .frame_err(ferr_w[0]), .overrun(overrun_w[0]), .busy(busy_w[0]));

    serial_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .MSB_FIRST(0)) dut1 (
        .m_clock(m_clock), .p_reset(p_reset), .RDX(rdx[1]), .rx_data(rx_data_w[1]),
        .rx_valid(rx_valid_w[1]), .rx_ready(rx_ready[1]), .parity_err(perr_w[1]),
        .frame_err(ferr_w[1]), .overrun(overrun_w[1]), .busy(busy_w[1]));

    serial_rx #(.CLKS_PER_BIT(13), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .MSB_FIRST(1)) dut2 (
        .m_clock(m_clock), .p_reset(p_reset), .RDX(rdx[2]), .rx_data(rx_data_w[2]),
        .rx_valid(rx_valid_w[2]), .rx_ready(rx_ready[2]), .parity_err(perr_w[2]),
        .frame_err(ferr_w[2]), .overrun(overrun_w[2]), .busy(busy_w[2]));

    function automatic int cpb(input int g);
        return (g == 2) ? 13 : 16;
    endfunction

    function automatic int par_mode(input int g);
        return g;
    endfunction

    function automatic int stop_bits(input int g);
        return (g == 2) ? 2 : 1;
    endfunction

    function automatic bit msb_first(input int g);
        return (g == 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge m_clock);
            #1;
        end
    endtask

    // Builds the line waveform from the frame rules and pushes the expected word before transmitting.
    task automatic applyStimulus(input int g, input logic [7:0] data, input int par_sel,
                                 input logic [1:0] stops, input logic drop);
        logic bits[$];
        exp_t e;
        logic pb;
        int   ones;
        e.inst = g;
        e.data = data;
        e.perr = 1'b0;
        e.ferr = 1'b0;
        e.drop = drop;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(msb_first(g) ? data[7-i] : data[i]);
        if (par_mode(g) != 0) begin
            ones = $countones(data);
            if (par_sel < 0) pb = ((ones % 2) == 1) ^ (par_mode(g) == 2);
            else             pb = par_sel[0];
            bits.push_back(pb);
            ones = ones + int'(pb);
            e.perr = (par_mode(g) == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
        end
        for (int s = 0; s < stop_bits(g); s++) begin
            bits.push_back(stops[s]);
            if (!stops[s]) e.ferr = 1'b1;
        end
        sb_q.push_back(e);
        foreach (bits[i]) begin
            rdx[g] = bits[i];
            wait_cycles(cpb(g));
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 4000) begin
            @(posedge m_clock);
            n++;
        end
        #1;
        check(name, sb_q.size(), 0);
    endtask

    task automatic pulse_reset(input int n);
        p_reset = 1'b1;
        wait_cycles(n);
        p_reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a fresh word appears or an overrun pulse is seen.
    task automatic checkOutput(input int g);
        exp_t e;
        bit   new_word;
        if (rx_valid_w[g]) valid_cycles[g]++;
        if (busy_w[g]) busy_cycles[g]++;
        if (overrun_w[g]) begin
            overrun_cycles[g]++;
            check($sformatf("overrun_width%0d", g), {31'b0, prev_ovr[g]}, 0);
            check($sformatf("overrun_pending%0d", g), {31'b0, sb_q.size() > 0}, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check($sformatf("overrun_inst%0d", g), e.inst, g);
                check($sformatf("overrun_drop%0d", g), {31'b0, e.drop}, 1);
            end
        end
        new_word = rx_valid_w[g] && (!prev_valid[g] || prev_ready[g]);
        if (new_word) begin
            check($sformatf("word_pending%0d", g), {31'b0, sb_q.size() > 0}, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check($sformatf("word_inst%0d", g), e.inst, g);
                check($sformatf("word_drop%0d", g), {31'b0, e.drop}, 0);
                check($sformatf("word_data%0d", g), {24'b0, rx_data_w[g]}, {24'b0, e.data});
                check($sformatf("word_perr%0d", g), {31'b0, perr_w[g]}, {31'b0, e.perr});
                check($sformatf("word_ferr%0d", g), {31'b0, ferr_w[g]}, {31'b0, e.ferr});
            end
        end else if (rx_valid_w[g] && prev_valid[g]) begin
            check($sformatf("hold_data%0d", g), {24'b0, rx_data_w[g]}, {24'b0, prev_data[g]});
            check($sformatf("hold_flags%0d", g), {30'b0, perr_w[g], ferr_w[g]}, {30'b0, prev_perr[g], prev_ferr[g]});
        end
    endtask

    always @(negedge m_clock) begin
        for (int g = 0; g < NI; g++) begin
            if (!p_reset) checkOutput(g);
            prev_valid[g] = p_reset ? 1'b0 : rx_valid_w[g];
            prev_ready[g] = rx_ready[g];
            prev_ovr[g]   = p_reset ? 1'b0 : overrun_w[g];
            prev_data[g]  = rx_data_w[g];
            prev_perr[g]  = perr_w[g];
            prev_ferr[g]  = ferr_w[g];
        end
    end

    initial begin
        for (int g = 0; g < NI; g++) rx_ready[g] = 1'b1;
        forever begin
            @(posedge m_clock);
            #1;
            for (int g = 0; g < NI; g++) begin
                case (ready_mode[g])
                    0:       rx_ready[g] = 1'b1;
                    2:       rx_ready[g] = 1'b0;
                    default: rx_ready[g] = 1'($urandom_range(0, 1));
                endcase
            end
        end
    end

    initial begin
        repeat (200000) @(posedge m_clock);
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         gap;
        logic [1:0] stops;
        int         par_sel;
        for (int g = 0; g < NI; g++) begin
            rdx[g]            = 1'b1;
            ready_mode[g]     = 0;
            valid_cycles[g]   = 0;
            busy_cycles[g]    = 0;
            overrun_cycles[g] = 0;
        end
        @(posedge m_clock);
        #1;
        pulse_reset(4);
        wait_cycles(2);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("rst_valid%0d", g), {31'b0, rx_valid_w[g]}, 0);
            check($sformatf("rst_busy%0d", g), {31'b0, busy_w[g]}, 0);
            check($sformatf("rst_data%0d", g), {24'b0, rx_data_w[g]}, 0);
            check($sformatf("rst_flags%0d", g), {29'b0, perr_w[g], ferr_w[g], overrun_w[g]}, 0);
        end

        $display("[TB] 8N1 frame 0x5A with consumer always ready");
        valid_cycles[0] = 0;
        applyStimulus(0, 8'h5A, -1, 2'b11, 1'b0);
        wait_drain("drain_5a");
        wait_cycles(5);
        check("valid_pulse_5a", valid_cycles[0], 1);

        $display("[TB] start-bit glitch of 5 cycles");
        wait_cycles(5);
        valid_cycles[0] = 0;
        busy_cycles[0]  = 0;
        rdx[0] = 1'b0;
        wait_cycles(5);
        rdx[0] = 1'b1;
        wait_cycles(30);
        check("glitch_valid", valid_cycles[0], 0);
        check("glitch_busy_seen", {31'b0, busy_cycles[0] >= 1}, 1);
        check("glitch_busy_le9", {31'b0, busy_cycles[0] <= 9}, 1);
        check("glitch_idle", {31'b0, busy_w[0]}, 0);

        $display("[TB] even parity frames 0x03 with parity bit 1 and 0");
        applyStimulus(1, 8'h03, 1, 2'b11, 1'b0);
        applyStimulus(1, 8'h03, 0, 2'b11, 1'b0);
        wait_drain("drain_parity");

        $display("[TB] stop bit low, line held low 40 bit-times");
        valid_cycles[0] = 0;
        applyStimulus(0, 8'hA5, -1, 2'b00, 1'b0);
        wait_cycles(40 * 16);
        check("break_busy", {31'b0, busy_w[0]}, 1);
        check("break_words", valid_cycles[0], 1);
        check("break_pending", sb_q.size(), 0);
        rdx[0] = 1'b1;
        wait_cycles(10);
        check("break_exit", {31'b0, busy_w[0]}, 0);

        $display("[TB] overrun: consumer stalled, frames 0x11 then 0x22");
        ready_mode[0]     = 2;
        overrun_cycles[0] = 0;
        wait_cycles(3);
        applyStimulus(0, 8'h11, -1, 2'b11, 1'b0);
        applyStimulus(0, 8'h22, -1, 2'b11, 1'b1);
        wait_cycles(20);
        check("ovr_count", overrun_cycles[0], 1);
        check("ovr_data_kept", {24'b0, rx_data_w[0]}, 32'h11);
        check("ovr_valid_held", {31'b0, rx_valid_w[0]}, 1);
        ready_mode[0] = 0;
        wait_cycles(5);
        check("ovr_consumed", {31'b0, rx_valid_w[0]}, 0);
        wait_drain("drain_ovr");

        $display("[TB] reset during data bits of 0xFF, then 0x81");
        rdx[0] = 1'b0;
        wait_cycles(16);
        rdx[0] = 1'b1;
        wait_cycles(3 * 16);
        pulse_reset(2);
        wait_cycles(1);
        check("midrst_valid", {31'b0, rx_valid_w[0]}, 0);
        check("midrst_data", {24'b0, rx_data_w[0]}, 0);
        check("midrst_busy", {31'b0, busy_w[0]}, 0);
        wait_cycles(6 * 16);
        valid_cycles[0] = 0;
        applyStimulus(0, 8'h81, -1, 2'b11, 1'b0);
        wait_drain("drain_81");
        wait_cycles(5);
        check("midrst_words", valid_cycles[0], 1);
        applyStimulus(2, 8'h81, -1, 2'b11, 1'b0);
        applyStimulus(2, 8'h1C, -1, 2'b11, 1'b0);
        wait_drain("drain_msb");

        $display("[TB] randomized frames with random consumer");
        for (int g = 0; g < NI; g++) ready_mode[g] = 1;
        for (int g = 0; g < NI; g++) begin
            for (int n = 0; n < 12; n++) begin
                stops   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
                par_sel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
                applyStimulus(g, 8'($urandom), par_sel, stops, 1'b0);
                rdx[g] = 1'b1;
                gap = (stops[0] && (stop_bits(g) == 1 || stops[1])) ? int'($urandom_range(0, 20))
                                                                    : int'($urandom_range(4, 20));
                wait_cycles(gap);
            end
            wait_drain($sformatf("drain_rand%0d", g));
        end
        wait_cycles(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
